// File: rtl/accum_ctrl.sv
// accum_ctrl: write/accumulate and drain sequencer for one accumulator column slice.
// Optional macro ACCUM_CTRL_READY_EN adds the out_ready port for drain backpressure.
module accum_ctrl #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_COLS = 16,
    localparam int unsigned NUM_BLOCKS = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_BLOCKS,
    localparam int unsigned ADDR_W = $clog2(NUM_ACCUM_ROWS),
    localparam int unsigned ROW_W = $clog2(MAX_OUT_ROWS) + 1,
    localparam int unsigned BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [7:0]        num_passes,
    input  logic [BLK_W-1:0]  col_block,
    input  logic              sys_valid,
`ifdef ACCUM_CTRL_READY_EN
    input  logic              out_ready,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_first,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_d;
    logic [ROW_W-1:0]  row_cnt, row_cnt_d;
    logic [7:0]        pass_cnt, pass_cnt_d;
    logic [ADDR_W-1:0] base, base_d;
    logic [ROW_W-1:0]  num_rows_q, num_rows_d;
    logic [7:0]        num_passes_q, num_passes_d;
    logic              start_ok;
    logic              rd_go;

    assign start_ok = (num_rows != '0) && (32'(num_rows) <= MAX_OUT_ROWS) &&
                      (num_passes != 8'd0) && (32'(col_block) < NUM_BLOCKS);

`ifdef ACCUM_CTRL_READY_EN
    assign rd_go = out_ready;
`else
    assign rd_go = 1'b1;
`endif

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State, counters, latched config and the read-latency-aligned valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            row_cnt      <= '0;
            pass_cnt     <= '0;
            base         <= '0;
            num_rows_q   <= '0;
            num_passes_q <= '0;
            out_valid    <= 1'b0;
        end else begin
            state        <= state_d;
            row_cnt      <= row_cnt_d;
            pass_cnt     <= pass_cnt_d;
            base         <= base_d;
            num_rows_q   <= num_rows_d;
            num_passes_q <= num_passes_d;
            out_valid    <= rd_en;
        end
    end

    // Next-state, counter updates and memory-side strobes
    always_comb begin
        state_d      = state;
        row_cnt_d    = row_cnt;
        pass_cnt_d   = pass_cnt;
        base_d       = base;
        num_rows_d   = num_rows_q;
        num_passes_d = num_passes_q;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_first     = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        case (state)
            S_IDLE: begin
                if (start && start_ok) begin
                    state_d      = S_ACCUM;
                    num_rows_d   = num_rows;
                    num_passes_d = num_passes;
                    base_d       = ADDR_W'(col_block) * ADDR_W'(MAX_OUT_ROWS);
                    row_cnt_d    = '0;
                    pass_cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                wr_en    = sys_valid;
                wr_addr  = base + ADDR_W'(row_cnt);
                wr_first = (pass_cnt == 8'd0);
                if (sys_valid) begin
                    if (row_cnt == num_rows_q - ROW_W'(1)) begin
                        row_cnt_d  = '0;
                        pass_cnt_d = pass_cnt + 8'd1;
                        if (pass_cnt == num_passes_q - 8'd1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        row_cnt_d = row_cnt + ROW_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                rd_en   = rd_go;
                rd_addr = base + ADDR_W'(row_cnt);
                if (rd_go) begin
                    if (row_cnt == num_rows_q - ROW_W'(1)) begin
                        row_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        row_cnt_d = row_cnt + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
